hilo_div_unit: RTL and testbench

//  Multi-cycle DIV/DIVU execution unit with the architectural HI/LO registers.

---
 rtl/hilo_div_unit.sv | 155 +++++++++++++++
 tb/tb_hilo_div_unit.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/hilo_div_unit.sv
// hilo_div_unit: multi-cycle DIV/DIVU unit owning the architectural HI/LO registers.
// Latency: start accepted at edge 0 -> HI/LO written and o_done=1 after edge WIDTH+1.
// Backpressure: o_stall holds the EX stage on start/MFxx/MTxx while a divide runs.
//
// Ports:
//   i_clk, i_rst               clock, synchronous active-high reset
//   i_start, i_is_signed       issue DIV (signed) / DIVU (unsigned)
//   i_dividend, i_divisor      operands, captured when the start is accepted
//   i_mthi, i_mtlo, i_wdata    direct HI/LO writes (IDLE only)
//   i_hilo_read                EX stage holds MFHI/MFLO (affects stall only)
//   o_hi, o_lo                 HI (remainder) / LO (quotient)
//   o_busy, o_done, o_stall    status and interlock
module hilo_div_unit #(
  parameter int WIDTH = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_is_signed,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  input  logic             i_mthi,
  input  logic             i_mtlo,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_hilo_read,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_stall
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ITER = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;

  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic             r_done;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_rem;    // partial remainder, always < divisor
  logic [WIDTH-1:0] r_quo;    // dividend magnitude shifting out, quotient shifting in
  logic [WIDTH-1:0] r_dvs;    // divisor magnitude
  logic [WIDTH-1:0] r_raw;    // raw dividend, returned in HI on divide-by-zero
  logic             r_q_neg;
  logic             r_r_neg;
  logic             r_dz;

  // Operand magnitudes. The most-negative value negates to itself, which is
  // exactly its unsigned magnitude, so no extra bit is needed.
  logic             w_dd_neg;
  logic             w_dv_neg;
  logic [WIDTH-1:0] w_dd_abs;
  logic [WIDTH-1:0] w_dv_abs;

  assign w_dd_neg = i_is_signed & i_dividend[WIDTH-1];
  assign w_dv_neg = i_is_signed & i_divisor[WIDTH-1];
  assign w_dd_abs = w_dd_neg ? (~i_dividend + 1'b1) : i_dividend;
  assign w_dv_abs = w_dv_neg ? (~i_divisor + 1'b1) : i_divisor;

  // One restoring step. The shifted remainder is WIDTH+1 bits so the compare
  // never wraps; when it is >= divisor the true difference is < divisor, so
  // the low WIDTH bits of the subtraction are exact.
  logic [WIDTH:0]   w_shift;
  logic             w_ge;
  logic [WIDTH-1:0] w_sub;
  logic [WIDTH-1:0] w_rem_next;

  assign w_shift    = {r_rem, r_quo[WIDTH-1]};
  assign w_ge       = (w_shift >= {1'b0, r_dvs});
  assign w_sub      = w_shift[WIDTH-1:0] - r_dvs;
  assign w_rem_next = w_ge ? w_sub : w_shift[WIDTH-1:0];

  // Sign fix-up applied once the magnitudes are known.
  logic [WIDTH-1:0] w_lo_fix;
  logic [WIDTH-1:0] w_hi_fix;

  assign w_lo_fix = r_dz ? {WIDTH{1'b1}} :
                    (r_q_neg ? (~r_quo + 1'b1) : r_quo);
  assign w_hi_fix = r_dz ? r_raw :
                    (r_r_neg ? (~r_rem + 1'b1) : r_rem);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (i_start) w_next = S_ITER;
      S_ITER:  if (r_count == '0) w_next = S_FIX;
      S_FIX:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_hi    <= '0;
      r_lo    <= '0;
      r_done  <= 1'b0;
      r_count <= '0;
      r_rem   <= '0;
      r_quo   <= '0;
      r_dvs   <= '0;
      r_raw   <= '0;
      r_q_neg <= 1'b0;
      r_r_neg <= 1'b0;
      r_dz    <= 1'b0;
    end else begin
      r_state <= w_next;
      r_done  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            // A start in the same cycle as MTHI/MTLO takes priority; the moves are dropped.
            r_quo   <= w_dd_abs;
            r_dvs   <= w_dv_abs;
            r_rem   <= '0;
            r_raw   <= i_dividend;
            r_q_neg <= w_dd_neg ^ w_dv_neg;
            r_r_neg <= w_dd_neg;
            r_dz    <= (i_divisor == '0);
            r_count <= CW'(WIDTH - 1);
          end else begin
            if (i_mthi) r_hi <= i_wdata;
            if (i_mtlo) r_lo <= i_wdata;
          end
        end
        S_ITER: begin
          r_rem   <= w_rem_next;
          r_quo   <= {r_quo[WIDTH-2:0], w_ge};
          r_count <= r_count - 1'b1;
        end
        S_FIX: begin
          r_lo   <= w_lo_fix;
          r_hi   <= w_hi_fix;
          r_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign o_hi    = r_hi;
  assign o_lo    = r_lo;
  assign o_done  = r_done;
  assign o_busy  = (r_state != S_IDLE);
  assign o_stall = o_busy & (i_start | i_hilo_read | i_mthi | i_mtlo);

endmodule

// File: tb/tb_hilo_div_unit.sv
// tb_hilo_div_unit: directed vectors plus hand-written multi-cycle sequences for hilo_div_unit.
// Latency: each divide is expected to complete exactly 17 edges after its start edge.
// Backpressure: stall is checked every busy cycle with start/read/moves held.
module tb_hilo_div_unit;

  localparam int W = 16;

  logic         i_clk = 1'b0;
  logic         i_rst;
  logic         i_start;
  logic         i_is_signed;
  logic [W-1:0] i_dividend;
  logic [W-1:0] i_divisor;
  logic         i_mthi;
  logic         i_mtlo;
  logic [W-1:0] i_wdata;
  logic         i_hilo_read;
  logic [W-1:0] o_hi;
  logic [W-1:0] o_lo;
  logic         o_busy;
  logic         o_done;
  logic         o_stall;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 i_clk = ~i_clk;

  hilo_div_unit #(.WIDTH(W)) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_start     (i_start),
    .i_is_signed (i_is_signed),
    .i_dividend  (i_dividend),
    .i_divisor   (i_divisor),
    .i_mthi      (i_mthi),
    .i_mtlo      (i_mtlo),
    .i_wdata     (i_wdata),
    .i_hilo_read (i_hilo_read),
    .o_hi        (o_hi),
    .o_lo        (o_lo),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_stall     (o_stall)
  );

  typedef struct {
    bit           sgn;
    logic [W-1:0] dd;
    logic [W-1:0] dv;
    logic [W-1:0] lo;
    logic [W-1:0] hi;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance one edge and sample 1 time unit later.
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic launch(input bit s, input logic [W-1:0] dd, input logic [W-1:0] dv);
    i_is_signed = s;
    i_dividend  = dd;
    i_divisor   = dv;
    i_start     = 1'b1;
  endtask

  // Called just after the start edge (edge 0); waits for done with a bound.
  task automatic finish_div(input string name, input logic [W-1:0] elo, input logic [W-1:0] ehi);
    int k;
    k = 0;
    while (!o_done && k < 40) begin
      tick();
      k++;
    end
    chk({name, " latency"}, k, 17);
    chk({name, " lo"}, o_lo, elo);
    chk({name, " hi"}, o_hi, ehi);
  endtask

  task automatic run_div(input string name, input bit s, input logic [W-1:0] dd,
                         input logic [W-1:0] dv, input logic [W-1:0] elo,
                         input logic [W-1:0] ehi);
    launch(s, dd, dv);
    tick();
    i_start = 1'b0;
    chk({name, " busy"}, o_busy, 1'b1);
    finish_div(name, elo, ehi);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // {signed, dividend, divisor, lo, hi}
    vecs[0]  = '{1'b0, 16'h0064, 16'h0007, 16'h000E, 16'h0002};
    vecs[1]  = '{1'b1, 16'hFFF9, 16'h0002, 16'hFFFD, 16'hFFFF};
    vecs[2]  = '{1'b0, 16'hFFF9, 16'h0002, 16'h7FFC, 16'h0001};
    vecs[3]  = '{1'b1, 16'h1234, 16'h0000, 16'hFFFF, 16'h1234};
    vecs[4]  = '{1'b0, 16'h1234, 16'h0000, 16'hFFFF, 16'h1234};
    vecs[5]  = '{1'b1, 16'h8000, 16'hFFFF, 16'h8000, 16'h0000};
    vecs[6]  = '{1'b0, 16'h8000, 16'hFFFF, 16'h0000, 16'h8000};
    vecs[7]  = '{1'b1, 16'h0007, 16'hFFFE, 16'hFFFD, 16'h0001};
    vecs[8]  = '{1'b1, 16'hFFF9, 16'hFFFE, 16'h0003, 16'hFFFF};
    vecs[9]  = '{1'b0, 16'hFFFF, 16'h0010, 16'h0FFF, 16'h000F};
    vecs[10] = '{1'b1, 16'h8000, 16'h0000, 16'hFFFF, 16'h8000};

    i_rst = 1'b1; i_start = 1'b0; i_is_signed = 1'b0; i_dividend = '0; i_divisor = '0;
    i_mthi = 1'b0; i_mtlo = 1'b0; i_wdata = '0; i_hilo_read = 1'b0;
    tick();
    tick();
    chk("reset hi", o_hi, 16'h0);
    chk("reset lo", o_lo, 16'h0);
    chk("reset busy", o_busy, 1'b0);
    chk("reset done", o_done, 1'b0);
    i_rst = 1'b0;

    // Table-driven divides.
    for (int v = 0; v < 11; v++) begin
      run_div($sformatf("vec%0d", v), vecs[v].sgn, vecs[v].dd, vecs[v].dv,
              vecs[v].lo, vecs[v].hi);
      tick();
      chk($sformatf("vec%0d done pulse", v), o_done, 1'b0);
      chk($sformatf("vec%0d hold lo", v), o_lo, vecs[v].lo);
    end

    // Interlock: read, MTHI and a second start held for the whole divide.
    launch(1'b0, 16'h0064, 16'h0007);
    tick();
    i_start = 1'b1; i_dividend = 16'h0009; i_divisor = 16'h0003;
    i_hilo_read = 1'b1; i_mthi = 1'b1; i_wdata = 16'h5555;
    begin
      int k;
      k = 0;
      do begin
        chk("stall busy", o_stall, 1'b1);
        chk("stall lo stable", o_lo, 16'hFFFF);
        tick();
        k++;
      end while (!o_done && k < 40);
      chk("stall latency", k, 17);
      chk("stall idle", o_stall, 1'b0);
      i_start = 1'b0; i_hilo_read = 1'b0; i_mthi = 1'b0;
      chk("stall lo", o_lo, 16'h000E);
      chk("stall hi", o_hi, 16'h0002);
    end
    tick();
    chk("second start ignored", o_busy, 1'b0);
    chk("mthi ignored hi", o_hi, 16'h0002);

    // MTHI/MTLO in IDLE.
    i_mthi = 1'b1; i_wdata = 16'hABCD;
    tick();
    i_mthi = 1'b0;
    chk("mthi hi", o_hi, 16'hABCD);
    i_mtlo = 1'b1; i_wdata = 16'h1357;
    tick();
    i_mtlo = 1'b0;
    chk("mtlo lo", o_lo, 16'h1357);
    chk("mtlo hi kept", o_hi, 16'hABCD);
    i_mthi = 1'b1; i_mtlo = 1'b1; i_wdata = 16'h2468;
    tick();
    i_mthi = 1'b0; i_mtlo = 1'b0;
    chk("both hi", o_hi, 16'h2468);
    chk("both lo", o_lo, 16'h2468);

    // Start and MTHI in the same IDLE cycle: move dropped.
    launch(1'b0, 16'h0064, 16'h0007);
    i_mthi = 1'b1; i_wdata = 16'h9999;
    tick();
    i_start = 1'b0; i_mthi = 1'b0;
    chk("start wins hi", o_hi, 16'h2468);
    chk("start wins busy", o_busy, 1'b1);
    finish_div("start wins", 16'h000E, 16'h0002);
    tick();

    // Reset in the middle of a divide, then a start right after it.
    launch(1'b0, 16'h0064, 16'h0007);
    tick();
    i_start = 1'b0;
    repeat (4) tick();
    i_rst = 1'b1;
    tick();
    chk("abort busy", o_busy, 1'b0);
    chk("abort hi", o_hi, 16'h0);
    chk("abort lo", o_lo, 16'h0);
    chk("abort done", o_done, 1'b0);
    i_rst = 1'b0;
    run_div("after reset", 1'b0, 16'h0009, 16'h0003, 16'h0003, 16'h0000);
    tick();

    // Back-to-back: second start issued in the done cycle of the first.
    run_div("b2b first", 1'b1, 16'hFFF9, 16'h0002, 16'hFFFD, 16'hFFFF);
    launch(1'b0, 16'hFFFF, 16'h0010);
    tick();
    i_start = 1'b0;
    chk("b2b accepted", o_busy, 1'b1);
    chk("b2b done drop", o_done, 1'b0);
    finish_div("b2b second", 16'h0FFF, 16'h000F);
    tick();
    chk("b2b done end", o_done, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
